// File: rtl/imu_read_seq_if.sv
// -----------------------------------------------------------------------------
// imu_read_seq_if
//
// Command/response link between the IMU read sequencer and the SPI master.
//
// Handshake: the issuing side raises spi_wrt for exactly one cycle with
// spi_cmd valid in that same cycle. spi_cmd is then held until the next
// spi_wrt. Only one transaction may be outstanding. spi_wrt acts as "valid",
// and the SPI master is implicitly ready whenever no transaction is
// outstanding. The SPI master closes the transaction with a one-cycle
// spi_done pulse. spi_rd_data is valid only in that spi_done cycle.
//
// Signals:
//   spi_wrt      start pulse for one SPI transaction
//   spi_cmd      16-bit command word for the transaction
//   spi_done     completion pulse from the SPI master
//   spi_rd_data  byte returned by the transaction, valid with spi_done
//
// Modports:
//   master  the sequencer that issues commands
//   slave   the SPI master that executes them
// -----------------------------------------------------------------------------
interface imu_read_seq_if;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [7:0]  spi_rd_data;

  modport master (
    output spi_wrt,
    output spi_cmd,
    input  spi_done,
    input  spi_rd_data
  );

  modport slave (
    input  spi_wrt,
    input  spi_cmd,
    output spi_done,
    output spi_rd_data
  );
endinterface

// File: rtl/imu_read_seq.sv
// -----------------------------------------------------------------------------
// imu_read_seq
//
// Owns the SPI link to the inertial sensor. The sequence is:
//   1. After reset, wait INIT_WAIT cycles for the sensor to power up.
//   2. Write four configuration registers.
//   3. Each time the data-ready interrupt is seen, read pitch-rate low/high
//      and AZ low/high.
//   4. Publish the two assembled words with a one-cycle vld strobe.
//
// Parameters:
//   INIT_WAIT  idle cycles after reset before the first configuration write
//              (minimum 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   INT        sensor data-ready, asynchronous and level-sensitive
//   spi        command/response link to the SPI master (master modport)
//   init_done  high once all configuration writes have completed
//   ptch_rt    pitch rate {high byte, low byte}
//   AZ         Z acceleration {high byte, low byte}
//   vld        one-cycle strobe: ptch_rt/AZ hold a fresh sample
//   dbg_state  current FSM state, for observation only
// -----------------------------------------------------------------------------
module imu_read_seq #(
  parameter int unsigned INIT_WAIT = 16'hFFFF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           INT,
  imu_read_seq_if.master spi,
  output logic           init_done,
  output logic [15:0]    ptch_rt,
  output logic [15:0]    AZ,
  output logic           vld,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    WAIT_PWR  = 3'd0,
    CFG_ISSUE = 3'd1,
    CFG_WAIT  = 3'd2,
    IDLE      = 3'd3,
    RD_ISSUE  = 3'd4,
    RD_WAIT   = 3'd5,
    PUBLISH   = 3'd6
  } state_t;

  // Terminal value of the power-up counter.
  localparam logic [15:0] WAIT_LAST = 16'(INIT_WAIT - 1);

  state_t      state;
  logic [15:0] pwr_cnt;
  logic [1:0]  idx;
  logic [1:0]  idx_next;

  // Bytes of the current burst that arrive before the last one. The AZ high
  // byte is not stored: it goes straight from spi_rd_data into AZ, so both
  // words update together in the cycle after the final spi_done.
  logic [7:0]  rate_lo;
  logic [7:0]  rate_hi;
  logic [7:0]  az_lo;

  logic        int_meta;
  logic        int_sync;

  assign idx_next  = idx + 2'd1;
  assign dbg_state = state;

  // Configuration command for step i.
  function automatic logic [15:0] cfg_cmd(input logic [1:0] i);
    case (i)
      2'd0:    cfg_cmd = 16'h0D02;  // data-ready interrupt enable
      2'd1:    cfg_cmd = 16'h1053;  // accel ODR
      2'd2:    cfg_cmd = 16'h1150;  // gyro ODR
      default: cfg_cmd = 16'h1460;  // rounding
    endcase
  endfunction

  // Read command for step i.
  function automatic logic [15:0] rd_cmd(input logic [1:0] i);
    case (i)
      2'd0:    rd_cmd = 16'hA200;   // pitch-rate low
      2'd1:    rd_cmd = 16'hA300;   // pitch-rate high
      2'd2:    rd_cmd = 16'hAC00;   // AZ low
      default: rd_cmd = 16'hAD00;   // AZ high
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous data-ready level.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_meta <= 1'b0;
      int_sync <= 1'b0;
    end else begin
      int_meta <= INT;
      int_sync <= int_meta;
    end
  end

  // Sequencer.
  // spi_wrt/spi_cmd are loaded on the transition INTO an ISSUE state. That way
  // the registered pulse is high during the ISSUE cycle itself. As a result,
  // the next command goes out the cycle right after spi_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_PWR;
      pwr_cnt     <= 16'h0000;
      idx         <= 2'd0;
      spi.spi_wrt <= 1'b0;
      spi.spi_cmd <= 16'h0000;
      init_done   <= 1'b0;
      ptch_rt     <= 16'h0000;
      AZ          <= 16'h0000;
      vld         <= 1'b0;
      rate_lo     <= 8'h00;
      rate_hi     <= 8'h00;
      az_lo       <= 8'h00;
    end else begin
      // Pulse outputs default low; they are raised only on the transitions
      // below.
      spi.spi_wrt <= 1'b0;
      vld         <= 1'b0;

      case (state)
        WAIT_PWR: begin
          if (pwr_cnt == WAIT_LAST) begin
            idx         <= 2'd0;
            spi.spi_wrt <= 1'b1;
            spi.spi_cmd <= cfg_cmd(2'd0);
            state       <= CFG_ISSUE;
          end else begin
            pwr_cnt <= pwr_cnt + 16'd1;
          end
        end

        CFG_ISSUE: begin
          state <= CFG_WAIT;
        end

        CFG_WAIT: begin
          if (spi.spi_done) begin
            idx <= idx_next;
            if (idx == 2'd3) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              spi.spi_wrt <= 1'b1;
              spi.spi_cmd <= cfg_cmd(idx_next);
              state       <= CFG_ISSUE;
            end
          end
        end

        IDLE: begin
          if (int_sync) begin
            idx         <= 2'd0;
            spi.spi_wrt <= 1'b1;
            spi.spi_cmd <= rd_cmd(2'd0);
            state       <= RD_ISSUE;
          end
        end

        RD_ISSUE: begin
          state <= RD_WAIT;
        end

        RD_WAIT: begin
          if (spi.spi_done) begin
            idx <= idx_next;
            case (idx)
              2'd0:    rate_lo <= spi.spi_rd_data;
              2'd1:    rate_hi <= spi.spi_rd_data;
              2'd2:    az_lo   <= spi.spi_rd_data;
              default: ;
            endcase
            if (idx == 2'd3) begin
              // Both words load in one edge, so the integrator never sees a
              // half-updated sample.
              ptch_rt <= {rate_hi, rate_lo};
              AZ      <= {spi.spi_rd_data, az_lo};
              vld     <= 1'b1;
              state   <= PUBLISH;
            end else begin
              spi.spi_wrt <= 1'b1;
              spi.spi_cmd <= rd_cmd(idx_next);
              state       <= RD_ISSUE;
            end
          end
        end

        PUBLISH: begin
          // The sample was loaded on entry; this cycle carries the vld strobe.
          state <= IDLE;
        end

        default: begin
          state <= WAIT_PWR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imu_read_seq.sv
// -----------------------------------------------------------------------------
// tb_imu_read_seq
//
// Self-checking bench for imu_read_seq.
// - A responder answers every spi_wrt after a programmable latency.
// - A monitor logs every observable event with its cycle number.
// - Scenario tasks compare those logs against command order, timing and data
//   computed from the sequencer's rules.
// -----------------------------------------------------------------------------
module tb_imu_read_seq;
  localparam int INIT_WAIT = 8;
  localparam int TIMEOUT   = 400;
  localparam logic [15:0] CFG_CMDS [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  localparam logic [15:0] RD_CMDS  [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  logic        clk;
  logic        rst;
  logic        int_in;
  logic        init_done;
  logic [15:0] ptch_rt;
  logic [15:0] az;
  logic        vld;
  logic [2:0]  dbg_state;

  logic        resp_done;
  logic [7:0]  resp_data;
  logic        stray_done;
  logic [7:0]  stray_data;

  int          spi_lat;
  logic [7:0]  burst_bytes [4];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0;
  logic [15:0] last_pt;
  logic [15:0] last_az;

  imu_read_seq_if spi_bus ();

  assign spi_bus.spi_done    = resp_done | stray_done;
  assign spi_bus.spi_rd_data = stray_done ? stray_data : resp_data;

  imu_read_seq #(.INIT_WAIT(INIT_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (int_in),
    .spi       (spi_bus),
    .init_done (init_done),
    .ptch_rt   (ptch_rt),
    .AZ        (az),
    .vld       (vld),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- SPI responder ----------------
  // Read data is chosen by the register address in the command. Config writes
  // get an arbitrary byte back.
  function automatic logic [7:0] byte_for(input logic [15:0] cmd);
    case (cmd[15:8])
      8'hA2:   byte_for = burst_bytes[0];
      8'hA3:   byte_for = burst_bytes[1];
      8'hAC:   byte_for = burst_bytes[2];
      8'hAD:   byte_for = burst_bytes[3];
      default: byte_for = 8'($urandom);
    endcase
  endfunction

  initial begin
    int          pend;
    logic [15:0] cmd_hold;
    pend      = 0;
    cmd_hold  = 16'h0000;
    resp_done = 1'b0;
    resp_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      resp_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          resp_done = 1'b1;
          resp_data = byte_for(cmd_hold);
        end
      end
      if (spi_bus.spi_wrt) begin
        pend     = spi_lat;
        cmd_hold = spi_bus.spi_cmd;
      end
    end
  end

  // ---------------- monitor / event logs ----------------
  int          wrt_cyc_q[$];
  logic [15:0] wrt_cmd_q[$];
  int          done_cyc_q[$];
  int          vld_cyc_q[$];
  logic [15:0] vld_pt_q[$];
  logic [15:0] vld_az_q[$];
  int          init_rise_q[$];
  int          overlap_cnt;
  int          chg_cnt;

  initial begin
    bit          outstanding;
    logic [15:0] prev_pt;
    logic [15:0] prev_az;
    logic        prev_init;
    outstanding = 1'b0;
    prev_pt     = 16'h0000;
    prev_az     = 16'h0000;
    prev_init   = 1'b0;
    overlap_cnt = 0;
    chg_cnt     = 0;
    forever begin
      @(posedge clk); #2;
      if (spi_bus.spi_wrt === 1'b1) begin
        if (outstanding) overlap_cnt++;
        outstanding = 1'b1;
        wrt_cyc_q.push_back(cyc);
        wrt_cmd_q.push_back(spi_bus.spi_cmd);
      end
      if (spi_bus.spi_done === 1'b1) begin
        outstanding = 1'b0;
        done_cyc_q.push_back(cyc);
      end
      if (vld === 1'b1) begin
        vld_cyc_q.push_back(cyc);
        vld_pt_q.push_back(ptch_rt);
        vld_az_q.push_back(az);
      end else if (ptch_rt !== prev_pt || az !== prev_az) begin
        chg_cnt++;
      end
      prev_pt = ptch_rt;
      prev_az = az;
      if (init_done === 1'b1 && prev_init !== 1'b1) init_rise_q.push_back(cyc);
      prev_init = init_done;
    end
  end

  // Main process steps at posedge + 3, after the monitor has logged the cycle.
  task automatic tick();
    @(posedge clk); #3;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst        = 1'b1;
    int_in     = 1'b0;
    stray_done = 1'b0;
    stray_data = 8'h00;
    spi_lat    = 5;
    burst_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    last_pt    = 16'h0000;
    last_az    = 16'h0000;
    repeat (3) tick();
    checks++; if (spi_bus.spi_wrt !== 1'b0) begin errors++; $display("FAIL reset_spi_wrt: got %b expected 0 (state %0d)", spi_bus.spi_wrt, dbg_state); end
    checks++; if (spi_bus.spi_cmd !== 16'h0000) begin errors++; $display("FAIL reset_spi_cmd: got %h expected 0000", spi_bus.spi_cmd); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    checks++; if (ptch_rt !== 16'h0000) begin errors++; $display("FAIL reset_ptch_rt: got %h expected 0000", ptch_rt); end
    checks++; if (az !== 16'h0000) begin errors++; $display("FAIL reset_az: got %h expected 0000", az); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", vld); end
    rst = 1'b0;
    t0  = cyc;   // first cycle with rst low
  endtask

  task automatic test_stray_wait_pwr();
    int wb;
    wb = wrt_cyc_q.size();
    tick();
    stray_data = 8'hFF;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    repeat (3) tick();
    checks++; if (wrt_cyc_q.size() != wb) begin errors++; $display("FAIL stray_pwr_wrt: got %0d commands expected %0d", wrt_cyc_q.size() - wb, 0); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL stray_pwr_init_done: got %b expected 0", init_done); end
  endtask

  // Configuration writes go out at ts+INIT_WAIT, then one per (lat+1) cycles.
  task automatic test_power_up(input int ts, input int b);
    int ir;
    int vb;
    int exp_c;
    ir = init_rise_q.size();
    vb = vld_cyc_q.size();
    for (int i = 0; i < TIMEOUT && (wrt_cyc_q.size() < b + 4 || init_rise_q.size() <= ir); i++) tick();
    checks++;
    if (wrt_cyc_q.size() < b + 4 || init_rise_q.size() <= ir) begin
      errors++;
      $display("FAIL cfg_timeout: got %0d commands expected 4", wrt_cyc_q.size() - b);
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_c = ts + INIT_WAIT + k * (spi_lat + 1);
        checks++; if (wrt_cmd_q[b+k] !== CFG_CMDS[k]) begin errors++; $display("FAIL cfg_cmd%0d: got %h expected %h", k, wrt_cmd_q[b+k], CFG_CMDS[k]); end
        checks++; if (wrt_cyc_q[b+k] != exp_c) begin errors++; $display("FAIL cfg_time%0d: got cycle %0d expected %0d", k, wrt_cyc_q[b+k], exp_c); end
      end
      exp_c = ts + INIT_WAIT + 4 * (spi_lat + 1);
      checks++; if (init_rise_q[ir] != exp_c) begin errors++; $display("FAIL init_done_time: got cycle %0d expected %0d", init_rise_q[ir], exp_c); end
    end
    int_in = 1'b0;
    repeat (20) tick();
    checks++; if (wrt_cyc_q.size() != b + 4) begin errors++; $display("FAIL idle_no_cmd: got %0d commands expected 4", wrt_cyc_q.size() - b); end
    checks++; if (vld_cyc_q.size() != vb) begin errors++; $display("FAIL idle_no_vld: got %0d strobes expected 0", vld_cyc_q.size() - vb); end
    checks++; if (ptch_rt !== 16'h0000 || az !== 16'h0000) begin errors++; $display("FAIL cfg_outputs: got %h/%h expected 0000/0000", ptch_rt, az); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_level: got %b expected 1", init_done); end
  endtask

  task automatic test_read_burst(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3,
                                 input int lat);
    int          wb;
    int          vb;
    int          cc;
    int          tt;
    int          exp_c;
    logic [15:0] exp_pt;
    logic [15:0] exp_az;
    spi_lat     = lat;
    burst_bytes = '{b0, b1, b2, b3};
    exp_pt      = {b1, b0};
    exp_az      = {b3, b2};
    wb = wrt_cyc_q.size();
    vb = vld_cyc_q.size();
    cc = chg_cnt;
    int_in = 1'b1;
    tt = cyc;
    tick();
    int_in = 1'b0;
    for (int i = 0; i < TIMEOUT && vld_cyc_q.size() <= vb; i++) tick();
    repeat (8) tick();
    checks++;
    if (vld_cyc_q.size() <= vb || wrt_cyc_q.size() < wb + 4) begin
      errors++;
      $display("FAIL burst_timeout: got %0d strobes expected 1", vld_cyc_q.size() - vb);
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_c = tt + 3 + k * (lat + 1);
        checks++; if (wrt_cmd_q[wb+k] !== RD_CMDS[k]) begin errors++; $display("FAIL rd_cmd%0d: got %h expected %h", k, wrt_cmd_q[wb+k], RD_CMDS[k]); end
        checks++; if (wrt_cyc_q[wb+k] != exp_c) begin errors++; $display("FAIL rd_time%0d: got cycle %0d expected %0d", k, wrt_cyc_q[wb+k], exp_c); end
      end
      exp_c = tt + 3 + 4 * (lat + 1);
      checks++; if (vld_cyc_q[vb] != exp_c) begin errors++; $display("FAIL vld_time: got cycle %0d expected %0d", vld_cyc_q[vb], exp_c); end
      checks++; if (vld_pt_q[vb] !== exp_pt) begin errors++; $display("FAIL burst_ptch_rt: got %h expected %h", vld_pt_q[vb], exp_pt); end
      checks++; if (vld_az_q[vb] !== exp_az) begin errors++; $display("FAIL burst_az: got %h expected %h", vld_az_q[vb], exp_az); end
    end
    checks++; if (vld_cyc_q.size() != vb + 1) begin errors++; $display("FAIL burst_vld_count: got %0d expected 1", vld_cyc_q.size() - vb); end
    checks++; if (wrt_cyc_q.size() != wb + 4) begin errors++; $display("FAIL burst_cmd_count: got %0d expected 4", wrt_cyc_q.size() - wb); end
    checks++; if (chg_cnt != cc) begin errors++; $display("FAIL burst_stable: got %0d changes without vld expected 0", chg_cnt - cc); end
    last_pt = exp_pt;
    last_az = exp_az;
  endtask

  task automatic test_stray_idle();
    int wb;
    int vb;
    wb = wrt_cyc_q.size();
    vb = vld_cyc_q.size();
    stray_data = 8'hFF;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    repeat (10) tick();
    checks++; if (wrt_cyc_q.size() != wb) begin errors++; $display("FAIL stray_idle_wrt: got %0d commands expected 0", wrt_cyc_q.size() - wb); end
    checks++; if (vld_cyc_q.size() != vb) begin errors++; $display("FAIL stray_idle_vld: got %0d strobes expected 0", vld_cyc_q.size() - vb); end
    checks++; if (ptch_rt !== last_pt || az !== last_az) begin errors++; $display("FAIL stray_idle_data: got %h/%h expected %h/%h", ptch_rt, az, last_pt, last_az); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL stray_idle_init: got %b expected 1", init_done); end
  endtask

  task automatic test_back_to_back();
    int wb;
    int vb;
    int tt;
    int lat;
    int exp_c;
    bit swapped;
    lat         = $urandom_range(1, 8);
    spi_lat     = lat;
    burst_bytes = '{8'h01, 8'h00, 8'h02, 8'h00};
    swapped     = 1'b0;
    wb = wrt_cyc_q.size();
    vb = vld_cyc_q.size();
    int_in = 1'b1;
    tt = cyc;
    for (int i = 0; i < TIMEOUT && vld_cyc_q.size() < vb + 2; i++) begin
      tick();
      if (!swapped && vld_cyc_q.size() >= vb + 1) begin
        burst_bytes = '{8'h03, 8'h00, 8'h04, 8'h00};
        swapped = 1'b1;
      end
      // Drop the level once the second burst has started so no third begins.
      if (wrt_cyc_q.size() >= wb + 5) int_in = 1'b0;
    end
    int_in = 1'b0;
    repeat (12) tick();
    checks++; if (vld_cyc_q.size() != vb + 2) begin errors++; $display("FAIL b2b_vld_count: got %0d expected 2", vld_cyc_q.size() - vb); end
    checks++; if (wrt_cyc_q.size() != wb + 8) begin errors++; $display("FAIL b2b_cmd_count: got %0d expected 8", wrt_cyc_q.size() - wb); end
    if (vld_cyc_q.size() >= vb + 2 && wrt_cyc_q.size() >= wb + 8) begin
      for (int k = 0; k < 8; k++) begin
        checks++; if (wrt_cmd_q[wb+k] !== RD_CMDS[k%4]) begin errors++; $display("FAIL b2b_cmd%0d: got %h expected %h", k, wrt_cmd_q[wb+k], RD_CMDS[k%4]); end
      end
      exp_c = tt + 3 + 4 * (lat + 1);
      checks++; if (vld_cyc_q[vb] != exp_c) begin errors++; $display("FAIL b2b_vld1_time: got cycle %0d expected %0d", vld_cyc_q[vb], exp_c); end
      exp_c = exp_c + 2 + 4 * (lat + 1);
      checks++; if (vld_cyc_q[vb+1] != exp_c) begin errors++; $display("FAIL b2b_vld2_time: got cycle %0d expected %0d", vld_cyc_q[vb+1], exp_c); end
      checks++; if (vld_pt_q[vb] !== 16'h0001 || vld_az_q[vb] !== 16'h0002) begin errors++; $display("FAIL b2b_sample1: got %h/%h expected 0001/0002", vld_pt_q[vb], vld_az_q[vb]); end
      checks++; if (vld_pt_q[vb+1] !== 16'h0003 || vld_az_q[vb+1] !== 16'h0004) begin errors++; $display("FAIL b2b_sample2: got %h/%h expected 0003/0004", vld_pt_q[vb+1], vld_az_q[vb+1]); end
    end
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL spi_overlap: got %0d overlapping commands expected 0", overlap_cnt); end
    last_pt = 16'h0003;
    last_az = 16'h0004;
  endtask

  task automatic test_mid_burst_reset();
    int db;
    int vb;
    int ts;
    spi_lat     = 5;
    burst_bytes = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    db = done_cyc_q.size();
    vb = vld_cyc_q.size();
    int_in = 1'b1;
    tick();
    int_in = 1'b0;
    for (int i = 0; i < TIMEOUT && done_cyc_q.size() < db + 2; i++) tick();
    checks++; if (done_cyc_q.size() < db + 2) begin errors++; $display("FAIL mid_reset_timeout: got %0d dones expected 2", done_cyc_q.size() - db); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ts  = cyc;
    checks++; if (spi_bus.spi_wrt !== 1'b0) begin errors++; $display("FAIL mid_reset_spi_wrt: got %b expected 0", spi_bus.spi_wrt); end
    checks++; if (spi_bus.spi_cmd !== 16'h0000) begin errors++; $display("FAIL mid_reset_spi_cmd: got %h expected 0000", spi_bus.spi_cmd); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_reset_init_done: got %b expected 0", init_done); end
    checks++; if (ptch_rt !== 16'h0000 || az !== 16'h0000) begin errors++; $display("FAIL mid_reset_data: got %h/%h expected 0000/0000", ptch_rt, az); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL mid_reset_vld: got %b expected 0", vld); end
    test_power_up(ts, wrt_cyc_q.size());
    checks++; if (vld_cyc_q.size() != vb) begin errors++; $display("FAIL aborted_vld: got %0d strobes expected 0", vld_cyc_q.size() - vb); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_stray_wait_pwr();
    test_power_up(t0, 0);
    test_read_burst(8'h34, 8'h12, 8'h80, 8'hFE, 5);
    for (int n = 0; n < 3; n++) begin
      test_read_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      $urandom_range(1, 8));
    end
    test_stray_idle();
    test_back_to_back();
    test_mid_burst_reset();
    test_read_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imu_read_seq.md
# imu_read_seq

Sequencer that owns the SPI link to the inertial sensor and feeds the pitch integrator. After reset it waits for sensor power-up and writes four configuration registers. It then waits for the sensor's data-ready interrupt and reads four bytes: pitch-rate low/high and AZ low/high. It presents the assembled `ptch_rt`/`AZ` words with a one-cycle `vld` strobe. It sits between the SPI master and the integrator, and is the only block that issues SPI commands.

## Interface
- `INIT_WAIT`, default 16'hFFFF: clock cycles held idle after reset before the first configuration write. Minimum 1.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `INT`  input  1  sensor data-ready, asynchronous. Double-flopped internally, level-sensitive.
- `spi_wrt`  output  1  one-cycle start pulse to the SPI master.
- `spi_cmd`  output  16  command word. Valid on the `spi_wrt` cycle and held until the next `spi_wrt`.
- `spi_done`  input  1  one-cycle pulse from the SPI master marking transaction completion.
- `spi_rd_data`  input  8  read byte from the SPI master, valid on the `spi_done` cycle.
- `init_done`  output  1  high once all configuration writes have completed. Stays high until reset.
- `ptch_rt`  output  16  pitch rate, {high byte, low byte}.
- `AZ`  output  16  Z acceleration, {high byte, low byte}.
- `vld`  output  1  one-cycle strobe: `ptch_rt`/`AZ` hold a fresh sample.

## Operation
- FSM states: WAIT_PWR, CFG_ISSUE, CFG_WAIT, IDLE, RD_ISSUE, RD_WAIT, PUBLISH. A 2-bit index selects the configuration or read step.
- Configuration commands, in order: 16'h0D02 (data-ready interrupt enable), 16'h1053 (accel ODR), 16'h1150 (gyro ODR), 16'h1460 (rounding).
- Read commands, in order: 16'hA200 (pitch-rate low), 16'hA300 (pitch-rate high), 16'hAC00 (AZ low), 16'hAD00 (AZ high).
- WAIT_PWR: a 16-bit counter increments from 0. When it equals `INIT_WAIT-1`, go to CFG_ISSUE with index 0.
- CFG_ISSUE: assert `spi_wrt` and drive the `spi_cmd` for the current index. Go to CFG_WAIT.
- CFG_WAIT: on `spi_done`, increment the index.
  - If the index was 3, set `init_done` and go to IDLE.
  - Otherwise go to CFG_ISSUE.
- IDLE: when the synchronized `INT` is high, go to RD_ISSUE with index 0.
- RD_ISSUE/RD_WAIT: same handshake as configuration. On each `spi_done`, capture `spi_rd_data` into that step's byte register.
- After the index-3 `spi_done`, go to PUBLISH.
- PUBLISH: load `ptch_rt` and `AZ` from the four byte registers simultaneously and pulse `vld`. Return to IDLE.
- `ptch_rt`/`AZ` change only in PUBLISH; the integrator never sees a half-updated word.
- `spi_done` in any state other than CFG_WAIT/RD_WAIT is ignored: no capture, no state change.
- `INT` is ignored outside IDLE. A level still high on return to IDLE starts a new burst.
- Reset in any state returns to WAIT_PWR, clears the counter, index and `init_done`, and re-runs the full configuration.

## Timing
- Reset values: `spi_wrt`=0, `spi_cmd`=16'h0000, `init_done`=0, `ptch_rt`=16'h0000, `AZ`=16'h0000, `vld`=0.
- All outputs are registered.
- First `spi_wrt`: cycle `INIT_WAIT+1` after the first cycle with `rst` low.
- `spi_wrt` is high for exactly one cycle per command. No second `spi_wrt` is issued until `spi_done` has been seen.
- If `spi_done` arrives in cycle D, the next `spi_wrt` is at D+1 (it passes through the ISSUE state).
- `init_done` rises at D+1 after the fourth configuration `spi_done`.
- `INT` rising at cycle T reaches the FSM at T+2 (sync); the first read `spi_wrt` is at T+3 when in IDLE.
- Fourth read `spi_done` at cycle D: `vld`=1 and the new `ptch_rt`/`AZ` are visible at D+1. `vld` is 0 at D+2.

## Test plan
- Power-up, `INIT_WAIT`=8, SPI model returns `spi_done` 5 cycles after each `spi_wrt`.
  - Required: `spi_wrt` at cycle 9 with 16'h0D02, then 16'h1053, 16'h1150, 16'h1460.
  - Required: `init_done` rises 1 cycle after the 4th done.
  - Required: no `vld` and no further commands while `INT`=0.
- Read burst: `INT` pulsed high; SPI returns 8'h34, 8'h12, 8'h80, 8'hFE.
  - Required: commands A200, A300, AC00, AD00 in order.
  - Required: a single `vld` with `ptch_rt`=16'h1234 and `AZ`=16'hFE80.
  - Required: both outputs unchanged during the burst.
- Stray handshake: inject `spi_done` with data 8'hFF while in IDLE and during WAIT_PWR.
  - Required: no state change, no capture, no `spi_wrt`.
- Back-to-back: hold `INT` high through two bursts (data 8'h01, 8'h00, 8'h02, 8'h00, then 8'h03, 8'h00, 8'h04, 8'h00).
  - Required: two `vld` pulses, with `ptch_rt`/`AZ` = 1/2, then 3/4.
  - Required: `spi_wrt` never overlaps an outstanding transaction.
- Mid-burst reset: assert `rst` for 1 cycle after the 2nd read done.
  - Required: all outputs return to reset values and `init_done`=0.
  - Required: the configuration sequence restarts after `INIT_WAIT`; no `vld` from the aborted burst.
